// File: rtl/ahb_apb_bridge_if.sv
// Bus bundle for the AHB-lite to APB3 bridge: AHB slave-slot signals plus the APB master side.
// "slave" is the bridge's view; "master" is the view of the surrounding system/testbench.
interface ahb_apb_bridge_if #(
    parameter int ADDR_W = 16
);
    logic              HSEL;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic [31:0]       HRDATA;
    logic              HRESP;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRDATA, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRDATA, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-lite slave that turns each single AHB transfer into one APB3 transfer, reporting
// PSLVERR and an optional ACCESS-phase timeout as a two-cycle AHB ERROR response.
module ahb_apb_bridge #(
    parameter int ADDR_W  = 16,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_apb_bridge_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    // Counter starts at 0 on the first ACCESS cycle, so the abort fires on count TIMEOUT-1.
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       hrdata_q, hrdata_d;
    logic              accept;
    logic              unused_bits;

    assign unused_bits = ^{bus.HADDR[31:ADDR_W], bus.HTRANS[0]};
    assign accept      = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        hrdata_d = hrdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept) begin
                    state_d  = S_SETUP;
                    paddr_d  = bus.HADDR[ADDR_W-1:0];
                    pwrite_d = bus.HWRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    if (bus.PSLVERR) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_DONE;
                        if (!pwrite_q) hrdata_d = bus.PRDATA;
                    end
                end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    state_d = S_ERR1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Strobes decode straight from the state flop so an async reset drops them at once.
    assign bus.PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign bus.PENABLE   = (state_q == S_ACCESS);
    assign bus.HREADYOUT = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
    assign bus.HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = bus.HWDATA;
endmodule
